// File: rtl/serializer_fsm_pkg.sv
// Shared types and defaults for the FIR output serializer.
package serializer_fsm_pkg;

  // Default word width; also the number of serial beats per word.
  localparam int unsigned SER_LENGTH = 24;

  // One-hot state encoding, matching the input deserializer.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b01,
    ST_SHIFT_OUT = 2'b10
  } ser_state_e;

endpackage : serializer_fsm_pkg

// File: rtl/serializer_fsm_if.sv
// Parallel word handshake (from FIR) and serial bit stream (to sink).
interface serializer_fsm_if #(
  parameter int unsigned LENGTH = serializer_fsm_pkg::SER_LENGTH
);
  logic [LENGTH-1:0] iv_din;
  logic              i_din_valid;
  logic              o_ready;
  logic              o_dout;
  logic              o_dout_valid;
  logic              o_last;
  logic              i_ready;

  // Serializer side: receives words, produces the bit stream.
  modport slave (
    input  iv_din, i_din_valid, i_ready,
    output o_ready, o_dout, o_dout_valid, o_last
  );

  // Environment side: FIR word source and serial sink.
  modport master (
    output iv_din, i_din_valid, i_ready,
    input  o_ready, o_dout, o_dout_valid, o_last
  );
endinterface : serializer_fsm_if

// File: rtl/serializer_fsm.sv
// Parallel-to-serial converter: one LENGTH-bit word in, LSB-first bits out,
// o_last marking the final bit of each word.
module serializer_fsm
  import serializer_fsm_pkg::*;
#(
  parameter int unsigned LENGTH = SER_LENGTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  serializer_fsm_if.slave bus
);

  localparam int unsigned              LENGTH_BITS = $clog2(LENGTH);
  localparam logic [LENGTH_BITS-1:0]   LAST_IDX    = LENGTH_BITS'(LENGTH - 1);

  ser_state_e              state_q, state_d;
  logic [LENGTH-1:0]       shreg_q, shreg_d;
  logic [LENGTH_BITS-1:0]  cnt_q,   cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    last_q,  last_d;
  logic                    accept_c;
  logic                    xfer_c;

  assign accept_c = i_en && (state_q == ST_IDLE) && ready_q && bus.i_din_valid;
  assign xfer_c   = i_en && valid_q && bus.i_ready;

  // State register; holds while the clock enable is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else if (i_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (xfer_c && (cnt_q == LAST_IDX)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the shift register, bit counter and handshake outputs.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (i_en) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            shreg_d = bus.iv_din;
            cnt_d   = '0;
            ready_d = 1'b0;
            valid_d = 1'b1;
            last_d  = (LENGTH == 1);
          end else begin
            ready_d = 1'b1;
            valid_d = 1'b0;
          end
        end
        ST_SHIFT_OUT: begin
          if (xfer_c) begin
            if (cnt_q == LAST_IDX) begin
              ready_d = 1'b1;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end else begin
              shreg_d = shreg_q >> 1;
              cnt_d   = cnt_q + LENGTH_BITS'(1);
              last_d  = ((cnt_q + LENGTH_BITS'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          ready_d = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers; reset drops any word in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // The current serial bit is always the LSB of the shift register.
  assign bus.o_dout       = shreg_q[0];
  assign bus.o_dout_valid = valid_q;
  assign bus.o_last       = last_q;
  assign bus.o_ready      = ready_q;

endmodule : serializer_fsm
